// File: rtl/cpu_pkg.sv
// Shared definitions for the sequential CPU control unit: opcode map,
// ALU function encodings, FSM states and the registered control bundle.
package cpu_pkg;

  // Opcode map of the extended instruction set.
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;
  localparam logic [7:0] OP_SLL   = 8'h0D;
  localparam logic [7:0] OP_SRL   = 8'h0E;
  localparam logic [7:0] OP_ROR   = 8'h0F;

  // ALU function select encodings.
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_ROR = 3'b110;

  // Controller states: decoding new instructions, or waiting on data memory.
  typedef enum logic {
    S_DECODE = 1'b0,
    S_MEM    = 1'b1
  } state_t;

  // Control signals driven towards the datapath.
  typedef struct packed {
    logic [2:0] aluop;
    logic       write_enable;
    logic       mux_comp;
    logic       mux_imm;
    logic       mux_mem;
    logic       j_trigger;
    logic       beq_trigger;
    logic       bne_trigger;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: maps an opcode to its control bundle and
// flags memory-access and undefined opcodes.
module opcode_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 8
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl,
  output logic                    is_mem,
  output logic                    is_illegal
);

  // Decode table; anything outside the map is reported as illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    ctrl       = '0;
    is_illegal = 1'b0;
    case (opcode)
      OPCODE_WIDTH'(OP_LOADI): begin ctrl.mux_imm = 1'b1; ctrl.write_enable = 1'b1; end
      OPCODE_WIDTH'(OP_MOV):   begin ctrl.aluop = ALU_FWD; ctrl.write_enable = 1'b1; end
      OPCODE_WIDTH'(OP_ADD):   begin ctrl.aluop = ALU_ADD; ctrl.write_enable = 1'b1; end
      OPCODE_WIDTH'(OP_SUB):   begin
        ctrl.aluop = ALU_ADD; ctrl.mux_comp = 1'b1; ctrl.write_enable = 1'b1;
      end
      OPCODE_WIDTH'(OP_AND):   begin ctrl.aluop = ALU_AND; ctrl.write_enable = 1'b1; end
      OPCODE_WIDTH'(OP_OR):    begin ctrl.aluop = ALU_OR;  ctrl.write_enable = 1'b1; end
      OPCODE_WIDTH'(OP_J):     ctrl.j_trigger = 1'b1;
      OPCODE_WIDTH'(OP_BEQ):   begin
        ctrl.aluop = ALU_ADD; ctrl.mux_comp = 1'b1; ctrl.beq_trigger = 1'b1;
      end
      OPCODE_WIDTH'(OP_LWD):   begin ctrl.mem_read = 1'b1; ctrl.mux_mem = 1'b1; end
      OPCODE_WIDTH'(OP_LWI):   begin
        ctrl.mux_imm = 1'b1; ctrl.mem_read = 1'b1; ctrl.mux_mem = 1'b1;
      end
      OPCODE_WIDTH'(OP_SWD):   ctrl.mem_write = 1'b1;
      OPCODE_WIDTH'(OP_SWI):   begin ctrl.mux_imm = 1'b1; ctrl.mem_write = 1'b1; end
      OPCODE_WIDTH'(OP_BNE):   begin
        ctrl.aluop = ALU_ADD; ctrl.mux_comp = 1'b1; ctrl.bne_trigger = 1'b1;
      end
      OPCODE_WIDTH'(OP_SLL):   begin
        ctrl.aluop = ALU_SLL; ctrl.mux_imm = 1'b1; ctrl.write_enable = 1'b1;
      end
      OPCODE_WIDTH'(OP_SRL):   begin
        ctrl.aluop = ALU_SRL; ctrl.mux_imm = 1'b1; ctrl.write_enable = 1'b1;
      end
      OPCODE_WIDTH'(OP_ROR):   begin
        ctrl.aluop = ALU_ROR; ctrl.mux_imm = 1'b1; ctrl.write_enable = 1'b1;
      end
      default:                 is_illegal = 1'b1;
    endcase
  end

  // Memory instructions are exactly those that raise a request strobe.
  assign is_mem = ctrl.mem_read | ctrl.mem_write;

endmodule

// File: rtl/seq_control_unit.sv
// Registered control unit: decodes instructions, holds memory requests and
// stalls the PC while data memory is busy, with a timeout abort.
module seq_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned ALUOP_WIDTH  = 3,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [OPCODE_WIDTH-1:0] OPCODE,
  input  logic                    INSTR_VALID,
  input  logic                    BUSYWAIT,
  output logic [ALUOP_WIDTH-1:0]  ALUOP,
  output logic                    WRITEENABLE,
  output logic                    MUXCOMP,
  output logic                    MUXIMM,
  output logic                    MUXMEM,
  output logic                    J_TRIGGER,
  output logic                    BEQ_TRIGGER,
  output logic                    BNE_TRIGGER,
  output logic                    MEM_READ,
  output logic                    MEM_WRITE,
  output logic                    PC_STALL,
  output logic                    ILLEGAL,
  output logic                    MEM_ERR
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MEM_TIMEOUT);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  ctrl_t                 ctrl_q, ctrl_d, dec_ctrl;
  logic                  stall_q, stall_d;
  logic                  illegal_q, illegal_d;
  logic                  err_q, err_d;
  logic                  dec_is_mem, dec_is_illegal;

  opcode_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_decoder (
    .opcode     (OPCODE),
    .ctrl       (dec_ctrl),
    .is_mem     (dec_is_mem),
    .is_illegal (dec_is_illegal)
  );

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  // Next state and next registered outputs; strobes default to idle each cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = '0;
    stall_d   = 1'b0;
    illegal_d = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_DECODE: begin
        if (INSTR_VALID) begin
          if (dec_is_illegal) begin
            illegal_d = 1'b1;
          end else begin
            // Memory opcodes decode with WRITEENABLE low and ALUOP forward.
            ctrl_d = dec_ctrl;
            if (dec_is_mem) begin
              stall_d = 1'b1;
              cnt_d   = '0;
              state_d = S_MEM;
            end
          end
        end
      end
      S_MEM: begin
        cnt_d = cnt_inc;
        if (!BUSYWAIT) begin
          // Access done: a load writes the memory data back for one cycle.
          if (ctrl_q.mem_read) begin
            ctrl_d.write_enable = 1'b1;
            ctrl_d.mux_mem      = 1'b1;
          end
          state_d = S_DECODE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          err_d   = 1'b1;
          state_d = S_DECODE;
        end else begin
          ctrl_d  = ctrl_q;
          stall_d = 1'b1;
        end
      end
      default: state_d = S_DECODE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_DECODE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      stall_q   <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle's state, independent of order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      stall_q   <= stall_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  assign ALUOP       = ALUOP_WIDTH'(ctrl_q.aluop);
  assign WRITEENABLE = ctrl_q.write_enable;
  assign MUXCOMP     = ctrl_q.mux_comp;
  assign MUXIMM      = ctrl_q.mux_imm;
  assign MUXMEM      = ctrl_q.mux_mem;
  assign J_TRIGGER   = ctrl_q.j_trigger;
  assign BEQ_TRIGGER = ctrl_q.beq_trigger;
  assign BNE_TRIGGER = ctrl_q.bne_trigger;
  assign MEM_READ    = ctrl_q.mem_read;
  assign MEM_WRITE   = ctrl_q.mem_write;
  assign PC_STALL    = stall_q;
  assign ILLEGAL     = illegal_q;
  assign MEM_ERR     = err_q;

endmodule
